glb_io_stream_ctrl: RTL and testbench
=====================================

# glb_io_stream_ctrl

GLB-side endpoint for one 17-bit IO tile lane. It is the far end of the IO core's ready/valid channels:
- Transmit engine: reads a configured address range from a GLB bank and streams the words onto `glb2io_17`.
- Receive engine: accepts words from `io2glb_17` and writes them to a configured address range.

Each engine has its own FSM, counters and a 2-entry buffer. The block sits in the GLB tile, one instance per IO lane.

## Interface
Parameters:
- `ADDR_W`, 10, bank word-address width
- `DATA_W`, 17, lane width; bit 16 is carried opaquely

Ports:
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `clk_en` in 1: global clock enable; when low, all state holds
- `flush` in 1: synchronous clear to idle; takes priority over `clk_en`
- `tx_start` in 1: pulse; latches `tx_base`/`tx_len` and starts the transmit engine
- `tx_base` in ADDR_W: first read address
- `tx_len` in ADDR_W+1: number of words to send
- `rx_start` in 1: pulse; latches `rx_base`/`rx_len` and starts the receive engine
- `rx_base` in ADDR_W: first write address
- `rx_len` in ADDR_W+1: number of words to receive
- `mem_rd_en` out 1: read request
- `mem_rd_addr` out ADDR_W: read address
- `mem_rd_data` in DATA_W: read data, valid exactly 1 cycle after `mem_rd_en`
- `mem_wr_en` out 1: write strobe
- `mem_wr_addr` out ADDR_W: write address
- `mem_wr_data` out DATA_W: write data
- `glb2io_17` out DATA_W: transmit data
- `glb2io_17_valid` out 1: transmit valid
- `glb2io_17_ready` in 1: transmit ready
- `io2glb_17` in DATA_W: receive data
- `io2glb_17_valid` in 1: receive valid
- `io2glb_17_ready` out 1: receive ready
- `tx_busy` out 1, `rx_busy` out 1: engine active
- `tx_done` out 1, `rx_done` out 1: 1-cycle completion pulses

## Operation
- **Reset values:** every output is 0, both FSMs are in IDLE, all counters and buffers are cleared.

**Transmit FSM (TX_IDLE, TX_RUN)**
- `tx_start` in TX_IDLE with `clk_en` high: latch the configuration, clear counters, go to TX_RUN.
- `tx_start` while in TX_RUN is ignored.
- Resources: a 2-entry buffer, an `inflight` flag for a read issued last cycle, and an `issued` counter (ADDR_W+1 bits).
- Read issue: `mem_rd_en` = TX_RUN & `clk_en` & (`issued` < len) & (occupancy + `inflight` − pop_this_cycle < 2).
- Read address: `mem_rd_addr` = base + `issued`, modulo 2^ADDR_W, so the range wraps at the top of the bank.
- Captured `mem_rd_data` is pushed into the buffer.
- `glb2io_17_valid` = buffer not empty; `glb2io_17` = buffer head.
- Pop occurs when valid & `glb2io_17_ready` & `clk_en`.
- Data stays stable while valid is high and no pop has occurred.
- Completion: when `issued` == len, the buffer is empty and `inflight` is 0, pulse `tx_done` and return to TX_IDLE.
- `tx_len` = 0: `tx_done` pulses on the cycle after the start, and no read is issued.

**Receive FSM (RX_IDLE, RX_RUN)**
- `rx_start` is handled the same way as `tx_start`; the receive side keeps a `received` counter.
- `io2glb_17_ready` = RX_RUN & `clk_en` & (`received` < len).
- On accept, the write is registered:
  - next cycle `mem_wr_en` = 1
  - `mem_wr_addr` = base + `received` (wraps at 2^ADDR_W)
  - `mem_wr_data` = the accepted word
  - `received` increments.
- `rx_done` pulses in the same cycle as the final `mem_wr_en`, and the FSM returns to RX_IDLE on that cycle.
- `rx_len` = 0: `rx_done` pulses on the cycle after the start.

**Common rules**
- **`clk_en` low:** no state changes, `mem_rd_en`, `mem_wr_en` and `io2glb_17_ready` are forced to 0, and `glb2io_17_valid` and its data hold.
- **`flush`:** both FSMs go to IDLE, buffers and counters clear, no done pulses are produced, and an outstanding read result is discarded.
- **Start during `flush`:** ignored.
- **`rst` mid-transfer:** immediate return to the reset values.
- **Independence:** the two engines are fully independent and may run concurrently.

## Timing
- `tx_start` sampled in cycle 0 → TX_RUN and `mem_rd_en` in cycle 1.
- `mem_rd_data` arrives in cycle 2 → `glb2io_17_valid` in cycle 3.
- With ready held high, throughput is 1 word/cycle: an N-word transfer has its last pop in cycle N+2 and `tx_done` in cycle N+3.
- Receive: accept in cycle t → `mem_wr_en` in cycle t+1. With valid held high, 1 word/cycle.
- Ready deasserting never loses or duplicates a word. The buffer never overflows because read issue is credit-limited.

## Test plan
- `tx_start` with base=5, len=4, ready always 1 → reads 5,6,7,8 in cycles 1-4; valid in cycles 3-6 with data mem[5..8] in order; `tx_done` in cycle 7.
- Same transfer with ready toggling 1,0,0,1,… → every word delivered exactly once, in order; data stable while stalled; no more than 2 reads outstanding beyond pops.
- base=1022, len=4, ADDR_W=10 → read addresses 1022, 1023, 0, 1; identical wrap check on the receive side.
- rx base=0, len=3, valid high with words 0x1_0001, 0x0_0002, 0x1_FFFF → three writes at addresses 0..2 carrying bit 16 intact; `rx_done` coincides with the write at address 2; ready drops afterwards.
- `clk_en` low for 3 cycles mid-transfer → no counter movement and no strobes; the transfer resumes with results identical to an unstalled run.
- `flush` (and separately `rst`) mid-transfer → both busy outputs 0 next cycle, no done pulse; a fresh start with len=2 then completes normally. len=0 starts → done pulses the following cycle.

Source files
------------

// File: rtl/glb_io_stream_ctrl.sv
// GLB-side endpoint for one IO tile lane: a transmit engine streams a bank address
// range onto glb2io_17, a receive engine writes io2glb_17 words into a bank range.
module glb_io_stream_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              flush,
   input  logic              tx_start,
   input  logic [ADDR_W-1:0] tx_base,
   input  logic [ADDR_W:0]   tx_len,
   input  logic              rx_start,
   input  logic [ADDR_W-1:0] rx_base,
   input  logic [ADDR_W:0]   rx_len,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic [DATA_W-1:0] glb2io_17,
   output logic              glb2io_17_valid,
   input  logic              glb2io_17_ready,
   input  logic [DATA_W-1:0] io2glb_17,
   input  logic              io2glb_17_valid,
   output logic              io2glb_17_ready,
   output logic              tx_busy,
   output logic              rx_busy,
   output logic              tx_done,
   output logic              rx_done
);

   localparam logic [0:0] TX_IDLE = 1'b0;
   localparam logic [0:0] TX_RUN  = 1'b1;
   localparam logic [0:0] RX_IDLE = 1'b0;
   localparam logic [0:0] RX_RUN  = 1'b1;

   // ---------------------------------------------------------------- transmit
   logic [0:0]        tx_state_q, tx_state_d;
   logic [ADDR_W-1:0] tx_base_q, tx_base_d;
   logic [ADDR_W:0]   tx_len_q, tx_len_d;
   logic [ADDR_W:0]   tx_issued_q, tx_issued_d;
   logic              tx_inflight_q, tx_inflight_d;
   logic              tx_hold_vld_q, tx_hold_vld_d;
   logic [DATA_W-1:0] tx_hold_q, tx_hold_d;
   logic [DATA_W-1:0] tx_buf_q [2];
   logic [DATA_W-1:0] tx_buf_d [2];
   logic              tx_head_q, tx_head_d;
   logic [1:0]        tx_cnt_q, tx_cnt_d;

   logic              tx_run;
   logic              tx_pop;
   logic              tx_push;
   logic              tx_push_idx;
   logic [DATA_W-1:0] tx_push_data;
   logic [2:0]        tx_used;
   logic              tx_rd_go;
   logic              tx_fin;

   assign tx_run       = (tx_state_q == TX_RUN);
   assign tx_pop       = (tx_cnt_q != 2'd0) && glb2io_17_ready && clk_en;
   assign tx_push      = clk_en && tx_inflight_q;
   assign tx_push_idx  = tx_head_q ^ tx_cnt_q[0];
   assign tx_push_data = tx_hold_vld_q ? tx_hold_q : mem_rd_data;
   // Buffer slots already spoken for (held words plus the read in flight) bound the issue rate.
   assign tx_used      = {1'b0, tx_cnt_q} + {2'b00, tx_inflight_q};
   assign tx_rd_go     = tx_run && clk_en && !flush && (tx_issued_q < tx_len_q)
                         && (tx_used < (3'd2 + {2'b00, tx_pop}));
   assign tx_fin       = tx_run && clk_en && !flush && (tx_issued_q == tx_len_q)
                         && (tx_cnt_q == 2'd0) && !tx_inflight_q;

   always_comb begin : tx_next
      // NOTE: every _d starts from its _q so no branch can leave it unassigned and infer a latch.
      tx_state_d    = tx_state_q;
      tx_base_d     = tx_base_q;
      tx_len_d      = tx_len_q;
      tx_issued_d   = tx_issued_q;
      tx_inflight_d = tx_inflight_q;
      tx_hold_vld_d = tx_hold_vld_q;
      tx_hold_d     = tx_hold_q;
      tx_buf_d      = tx_buf_q;
      tx_head_d     = tx_head_q;
      tx_cnt_d      = tx_cnt_q;

      if (flush) begin
         tx_state_d    = TX_IDLE;
         tx_base_d     = '0;
         tx_len_d      = '0;
         tx_issued_d   = '0;
         tx_inflight_d = 1'b0;
         tx_hold_vld_d = 1'b0;
         tx_hold_d     = '0;
         tx_buf_d[0]   = '0;
         tx_buf_d[1]   = '0;
         tx_head_d     = 1'b0;
         tx_cnt_d      = 2'd0;
      end else if (clk_en) begin
         if (tx_state_q == TX_IDLE) begin
            if (tx_start) begin
               tx_state_d  = TX_RUN;
               tx_base_d   = tx_base;
               tx_len_d    = tx_len;
               tx_issued_d = '0;
            end
         end else if (tx_fin) begin
            tx_state_d = TX_IDLE;
         end

         if (tx_rd_go) begin
            tx_issued_d = tx_issued_q + {{ADDR_W{1'b0}}, 1'b1};
         end
         tx_inflight_d = tx_rd_go;
         tx_hold_vld_d = 1'b0;

         if (tx_pop) begin
            tx_head_d = ~tx_head_q;
         end
         if (tx_push) begin
            tx_buf_d[tx_push_idx] = tx_push_data;
         end
         tx_cnt_d = tx_cnt_q + {1'b0, tx_push} - {1'b0, tx_pop};
      end else if (tx_inflight_q && !tx_hold_vld_q) begin
         // The bank answers one cycle after the request even while stalled; park that word here.
         tx_hold_d     = mem_rd_data;
         tx_hold_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin : tx_regs
      if (rst) begin
         tx_state_q    <= TX_IDLE;
         tx_base_q     <= '0;
         tx_len_q      <= '0;
         tx_issued_q   <= '0;
         tx_inflight_q <= 1'b0;
         tx_hold_vld_q <= 1'b0;
         tx_hold_q     <= '0;
         // NOTE: the two buffer slots drive glb2io_17 directly, so they are reset like any flop.
         tx_buf_q[0]   <= '0;
         tx_buf_q[1]   <= '0;
         tx_head_q     <= 1'b0;
         tx_cnt_q      <= 2'd0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         tx_state_q    <= tx_state_d;
         tx_base_q     <= tx_base_d;
         tx_len_q      <= tx_len_d;
         tx_issued_q   <= tx_issued_d;
         tx_inflight_q <= tx_inflight_d;
         tx_hold_vld_q <= tx_hold_vld_d;
         tx_hold_q     <= tx_hold_d;
         tx_buf_q[0]   <= tx_buf_d[0];
         tx_buf_q[1]   <= tx_buf_d[1];
         tx_head_q     <= tx_head_d;
         tx_cnt_q      <= tx_cnt_d;
      end
   end

   assign mem_rd_en       = tx_rd_go;
   assign mem_rd_addr     = tx_base_q + tx_issued_q[ADDR_W-1:0];
   assign glb2io_17       = tx_buf_q[tx_head_q];
   assign glb2io_17_valid = (tx_cnt_q != 2'd0);
   assign tx_busy         = tx_run;
   assign tx_done         = tx_fin;

   // ----------------------------------------------------------------- receive
   logic [0:0]        rx_state_q, rx_state_d;
   logic [ADDR_W-1:0] rx_base_q, rx_base_d;
   logic [ADDR_W:0]   rx_len_q, rx_len_d;
   logic [ADDR_W:0]   rx_recv_q, rx_recv_d;
   logic              rx_wr_en_q, rx_wr_en_d;
   logic [ADDR_W-1:0] rx_wr_addr_q, rx_wr_addr_d;
   logic [DATA_W-1:0] rx_wr_data_q, rx_wr_data_d;

   logic rx_run;
   logic rx_ready;
   logic rx_acc;
   logic rx_fin;

   assign rx_run   = (rx_state_q == RX_RUN);
   assign rx_ready = rx_run && clk_en && !flush && (rx_recv_q < rx_len_q);
   assign rx_acc   = rx_ready && io2glb_17_valid;
   // The last accept leaves received == len, so this lands on the final write strobe.
   assign rx_fin   = rx_run && clk_en && !flush && (rx_recv_q == rx_len_q);

   always_comb begin : rx_next
      rx_state_d   = rx_state_q;
      rx_base_d    = rx_base_q;
      rx_len_d     = rx_len_q;
      rx_recv_d    = rx_recv_q;
      rx_wr_en_d   = rx_wr_en_q;
      rx_wr_addr_d = rx_wr_addr_q;
      rx_wr_data_d = rx_wr_data_q;

      if (flush) begin
         rx_state_d   = RX_IDLE;
         rx_base_d    = '0;
         rx_len_d     = '0;
         rx_recv_d    = '0;
         rx_wr_en_d   = 1'b0;
         rx_wr_addr_d = '0;
         rx_wr_data_d = '0;
      end else if (clk_en) begin
         if (rx_state_q == RX_IDLE) begin
            if (rx_start) begin
               rx_state_d = RX_RUN;
               rx_base_d  = rx_base;
               rx_len_d   = rx_len;
               rx_recv_d  = '0;
            end
         end else if (rx_fin) begin
            rx_state_d = RX_IDLE;
         end

         rx_wr_en_d = rx_acc;
         if (rx_acc) begin
            rx_wr_addr_d = rx_base_q + rx_recv_q[ADDR_W-1:0];
            rx_wr_data_d = io2glb_17;
            rx_recv_d    = rx_recv_q + {{ADDR_W{1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin : rx_regs
      if (rst) begin
         rx_state_q   <= RX_IDLE;
         rx_base_q    <= '0;
         rx_len_q     <= '0;
         rx_recv_q    <= '0;
         rx_wr_en_q   <= 1'b0;
         rx_wr_addr_q <= '0;
         rx_wr_data_q <= '0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_base_q    <= rx_base_d;
         rx_len_q     <= rx_len_d;
         rx_recv_q    <= rx_recv_d;
         rx_wr_en_q   <= rx_wr_en_d;
         rx_wr_addr_q <= rx_wr_addr_d;
         rx_wr_data_q <= rx_wr_data_d;
      end
   end

   // A registered write pending across a stall is held and only strobed once clk_en returns.
   assign mem_wr_en       = rx_wr_en_q && clk_en;
   assign mem_wr_addr     = rx_wr_addr_q;
   assign mem_wr_data     = rx_wr_data_q;
   assign io2glb_17_ready = rx_ready;
   assign rx_busy         = rx_run;
   assign rx_done         = rx_fin;

endmodule

// File: tb/tb_glb_io_stream_ctrl.sv
// Directed bench for glb_io_stream_ctrl: per-cycle expected outputs computed from
// the documented cycle timing, with a behavioural one-cycle-latency bank model.
module tb_glb_io_stream_ctrl;

   localparam int AW = 10;
   localparam int DW = 17;

   logic          clk;
   logic          rst;
   logic          clk_en;
   logic          flush;
   logic          tx_start;
   logic [AW-1:0] tx_base;
   logic [AW:0]   tx_len;
   logic          rx_start;
   logic [AW-1:0] rx_base;
   logic [AW:0]   rx_len;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [DW-1:0] mem_wr_data;
   logic [DW-1:0] glb2io_17;
   logic          glb2io_17_valid;
   logic          glb2io_17_ready;
   logic [DW-1:0] io2glb_17;
   logic          io2glb_17_valid;
   logic          io2glb_17_ready;
   logic          tx_busy;
   logic          rx_busy;
   logic          tx_done;
   logic          rx_done;

   logic [DW-1:0] bank [1024];
   int n_checks = 0;
   int n_fails  = 0;

   glb_io_stream_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk             (clk),
      .rst             (rst),
      .clk_en          (clk_en),
      .flush           (flush),
      .tx_start        (tx_start),
      .tx_base         (tx_base),
      .tx_len          (tx_len),
      .rx_start        (rx_start),
      .rx_base         (rx_base),
      .rx_len          (rx_len),
      .mem_rd_en       (mem_rd_en),
      .mem_rd_addr     (mem_rd_addr),
      .mem_rd_data     (mem_rd_data),
      .mem_wr_en       (mem_wr_en),
      .mem_wr_addr     (mem_wr_addr),
      .mem_wr_data     (mem_wr_data),
      .glb2io_17       (glb2io_17),
      .glb2io_17_valid (glb2io_17_valid),
      .glb2io_17_ready (glb2io_17_ready),
      .io2glb_17       (io2glb_17),
      .io2glb_17_valid (io2glb_17_valid),
      .io2glb_17_ready (io2glb_17_ready),
      .tx_busy         (tx_busy),
      .rx_busy         (rx_busy),
      .tx_done         (tx_done),
      .rx_done         (rx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial mem_rd_data = '0;
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= bank[mem_rd_addr];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] mval(input int a);
      logic [DW-1:0] r;
      int t;
      t = a * 37 + 4660;
      r[DW-1] = a[0] ^ a[3];
      r[15:0] = t[15:0];
      return r;
   endfunction

   // Expected {rd_en, rd_addr, valid, data, done, busy} with ready held high, e cycles after start.
   function automatic logic [30:0] tx_exp(input int e, input int base, input int len);
      logic rd, v, d, b;
      logic [AW-1:0] a;
      logic [DW-1:0] dat;
      rd  = (e >= 1) && (e <= len);
      v   = (e >= 3) && (e <= len + 2);
      d   = (e == len + 3);
      b   = (e >= 1) && (e <= len + 3);
      a   = rd ? AW'((base + e - 1) % 1024) : {AW{1'b0}};
      dat = v ? mval((base + e - 3) % 1024) : {DW{1'b0}};
      return {rd, a, v, dat, d, b};
   endfunction

   function automatic logic [30:0] tx_obs();
      logic [AW-1:0] a;
      logic [DW-1:0] dat;
      a   = mem_rd_en ? mem_rd_addr : {AW{1'b0}};
      dat = glb2io_17_valid ? glb2io_17 : {DW{1'b0}};
      return {mem_rd_en, a, glb2io_17_valid, dat, tx_done, tx_busy};
   endfunction

   // Expected {ready, wr_en, wr_addr, wr_data, done, busy} with valid held high.
   function automatic logic [30:0] rx_exp(input int e, input int base, input int len,
                                          input logic [DW-1:0] dat);
      logic rdy, we, d, b;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      rdy = (e >= 1) && (e <= len);
      we  = (e >= 2) && (e <= len + 1);
      d   = (e == len + 1);
      b   = (e >= 1) && (e <= len + 1);
      a   = we ? AW'((base + e - 2) % 1024) : {AW{1'b0}};
      wd  = we ? dat : {DW{1'b0}};
      return {rdy, we, a, wd, d, b};
   endfunction

   function automatic logic [30:0] rx_obs();
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      a  = mem_wr_en ? mem_wr_addr : {AW{1'b0}};
      wd = mem_wr_en ? mem_wr_data : {DW{1'b0}};
      return {io2glb_17_ready, mem_wr_en, a, wd, rx_done, rx_busy};
   endfunction

   function automatic logic [61:0] all_out();
      return {mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, glb2io_17,
              glb2io_17_valid, io2glb_17_ready, tx_busy, rx_busy, tx_done, rx_done};
   endfunction

   task automatic drive_idle();
      clk_en          = 1'b1;
      flush           = 1'b0;
      tx_start        = 1'b0;
      rx_start        = 1'b0;
      tx_base         = '0;
      tx_len          = '0;
      rx_base         = '0;
      rx_len          = '0;
      glb2io_17_ready = 1'b0;
      io2glb_17       = '0;
      io2glb_17_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      tx_start = 1'b1;
      tx_len   = 11'd5;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (all_out() !== 62'd0) begin
         n_fails++;
         $display("FAIL reset_outputs got=%h exp=0", all_out());
      end
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
      @(negedge clk);
      #1;
      n_checks++;
      if (all_out() !== 62'd0) begin
         n_fails++;
         $display("FAIL after_reset_idle got=%h exp=0", all_out());
      end
   endtask

   task automatic run_tx(input string name, input int base, input int len);
      @(negedge clk);
      tx_base = AW'(base);
      tx_len  = (AW + 1)'(len);
      tx_start = 1'b1;
      glb2io_17_ready = 1'b1;
      for (int c = 1; c <= len + 4; c++) begin
         @(negedge clk);
         // A second start while running must be ignored.
         tx_start = (c == 2);
         tx_base  = (c == 2) ? AW'(300) : AW'(base);
         #1;
         n_checks++;
         if (tx_obs() !== tx_exp(c, base, len)) begin
            n_fails++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, c, tx_obs(), tx_exp(c, base, len));
         end
      end
      drive_idle();
   endtask

   task automatic test_tx_basic();
      run_tx("tx_basic", 5, 4);
   endtask

   task automatic test_tx_wrap();
      run_tx("tx_wrap", 1022, 4);
   endtask

   task automatic test_tx_stall();
      int pops, reads, dones, max_out;
      logic prev_stall;
      logic [DW-1:0] prev_data;
      bit finished;
      pops = 0; reads = 0; dones = 0; max_out = 0;
      prev_stall = 1'b0; prev_data = '0; finished = 1'b0;
      @(negedge clk);
      tx_base = 10'd5; tx_len = 11'd4; tx_start = 1'b1;
      for (int c = 1; c <= 40 && !finished; c++) begin
         @(negedge clk);
         tx_start = 1'b0;
         glb2io_17_ready = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
         #1;
         if (mem_rd_en) reads++;
         if (prev_stall) begin
            n_checks++;
            if ({glb2io_17_valid, glb2io_17} !== {1'b1, prev_data}) begin
               n_fails++;
               $display("FAIL tx_stall_hold cycle=%0d got=%b/%h exp=1/%h", c, glb2io_17_valid, glb2io_17, prev_data);
            end
         end
         if (glb2io_17_valid && glb2io_17_ready) begin
            n_checks++;
            if (glb2io_17 !== mval(5 + pops)) begin
               n_fails++;
               $display("FAIL tx_stall_order pop=%0d got=%h exp=%h", pops, glb2io_17, mval(5 + pops));
            end
            pops++;
         end
         if (reads - pops > max_out) max_out = reads - pops;
         prev_stall = glb2io_17_valid && !glb2io_17_ready;
         prev_data  = glb2io_17;
         if (tx_done) begin
            dones++;
            finished = 1'b1;
         end
      end
      n_checks++;
      if ({finished, pops, reads} !== {1'b1, 32'd4, 32'd4}) begin
         n_fails++;
         $display("FAIL tx_stall_totals got done=%0d pops=%0d reads=%0d exp done=1 pops=4 reads=4", finished, pops, reads);
      end
      n_checks++;
      if (max_out > 2) begin
         n_fails++;
         $display("FAIL tx_stall_credit got outstanding=%0d exp<=2", max_out);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({tx_busy, tx_done, glb2io_17_valid} !== 3'b000) begin
         n_fails++;
         $display("FAIL tx_stall_end got=%b exp=000", {tx_busy, tx_done, glb2io_17_valid});
      end
      drive_idle();
   endtask

   task automatic run_rx(input string name, input int base, input int len, input logic [DW-1:0] w [4]);
      logic [DW-1:0] dat;
      @(negedge clk);
      rx_base = AW'(base);
      rx_len  = (AW + 1)'(len);
      rx_start = 1'b1;
      for (int c = 1; c <= len + 2; c++) begin
         @(negedge clk);
         rx_start = 1'b0;
         io2glb_17_valid = 1'b1;
         io2glb_17 = (c <= len) ? w[c - 1] : 17'h00BAD;
         dat = (c >= 2 && c <= len + 1) ? w[c - 2] : {DW{1'b0}};
         #1;
         n_checks++;
         if (rx_obs() !== rx_exp(c, base, len, dat)) begin
            n_fails++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, c, rx_obs(), rx_exp(c, base, len, dat));
         end
      end
      drive_idle();
   endtask

   task automatic test_rx_basic();
      logic [DW-1:0] w [4];
      w[0] = 17'h1_0001; w[1] = 17'h0_0002; w[2] = 17'h1_FFFF; w[3] = '0;
      run_rx("rx_basic", 0, 3, w);
   endtask

   task automatic test_rx_wrap();
      logic [DW-1:0] w [4];
      w[0] = 17'h0_0100; w[1] = 17'h1_0101; w[2] = 17'h0_0102; w[3] = 17'h1_0103;
      run_rx("rx_wrap", 1022, 4, w);
   endtask

   task automatic test_clk_en();
      logic [30:0] te, re;
      logic [DW-1:0] dat;
      int e;
      bit frozen;
      @(negedge clk);
      tx_base = 10'd5;   tx_len = 11'd4; tx_start = 1'b1; glb2io_17_ready = 1'b1;
      rx_base = 10'd100; rx_len = 11'd3; rx_start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         tx_start = 1'b0;
         rx_start = 1'b0;
         frozen = (c >= 3) && (c <= 5);
         clk_en = !frozen;
         io2glb_17_valid = 1'b1;
         io2glb_17 = DW'(32'h1000 + c);
         e = (c <= 2) ? c : c - 3;
         if (frozen) begin
            te = {1'b0, {AW{1'b0}}, 1'b1, mval(5), 1'b0, 1'b1};
            re = {1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b1};
         end else begin
            te = tx_exp(e, 5, 4);
            dat = (e == 2) ? 17'h01001 : (e == 3) ? 17'h01002 : (e == 4) ? 17'h01006 : 17'h0;
            re = rx_exp(e, 100, 3, dat);
         end
         #1;
         n_checks++;
         if (tx_obs() !== te) begin
            n_fails++;
            $display("FAIL clk_en_tx cycle=%0d got=%h exp=%h", c, tx_obs(), te);
         end
         n_checks++;
         if (rx_obs() !== re) begin
            n_fails++;
            $display("FAIL clk_en_rx cycle=%0d got=%h exp=%h", c, rx_obs(), re);
         end
      end
      drive_idle();
   endtask

   task automatic test_flush();
      logic [6:0] exp7, obs7;
      @(negedge clk);
      tx_base = 10'd5;   tx_len = 11'd4; tx_start = 1'b1; glb2io_17_ready = 1'b1;
      rx_base = 10'd200; rx_len = 11'd3; rx_start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         tx_start = 1'b0;
         rx_start = 1'b0;
         io2glb_17_valid = 1'b1;
         io2glb_17 = DW'(32'h300 + c);
         flush = (c == 3);
         exp7 = (c <= 2) ? 7'b1100110 : (c == 3) ? 7'b1100001 : 7'b0000000;
         #1;
         obs7 = {tx_busy, rx_busy, tx_done, rx_done, mem_rd_en, io2glb_17_ready, glb2io_17_valid};
         n_checks++;
         if (obs7 !== exp7) begin
            n_fails++;
            $display("FAIL flush cycle=%0d got=%b exp=%b", c, obs7, exp7);
         end
      end
      drive_idle();
      run_tx("flush_restart", 20, 2);
      @(negedge clk);
      flush = 1'b1;
      tx_start = 1'b1; tx_len = 11'd2;
      rx_start = 1'b1; rx_len = 11'd2;
      @(negedge clk);
      drive_idle();
      #1;
      n_checks++;
      if ({tx_busy, rx_busy} !== 2'b00) begin
         n_fails++;
         $display("FAIL start_during_flush got=%b exp=00", {tx_busy, rx_busy});
      end
   endtask

   task automatic test_rst_mid();
      logic [DW-1:0] w [4];
      @(negedge clk);
      tx_base = 10'd5;  tx_len = 11'd4; tx_start = 1'b1; glb2io_17_ready = 1'b1;
      rx_base = 10'd40; rx_len = 11'd3; rx_start = 1'b1;
      io2glb_17_valid = 1'b1; io2glb_17 = 17'h02001;
      @(negedge clk);
      tx_start = 1'b0;
      rx_start = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (all_out() !== 62'd0) begin
         n_fails++;
         $display("FAIL rst_mid_outputs got=%h exp=0", all_out());
      end
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
      #1;
      n_checks++;
      if ({tx_busy, rx_busy, tx_done, rx_done} !== 4'b0000) begin
         n_fails++;
         $display("FAIL rst_mid_idle got=%b exp=0000", {tx_busy, rx_busy, tx_done, rx_done});
      end
      w[0] = 17'h1_2101; w[1] = 17'h0_2102; w[2] = '0; w[3] = '0;
      run_rx("rst_restart", 40, 2, w);
   endtask

   task automatic test_len_zero();
      logic [7:0] obs8;
      @(negedge clk);
      tx_len = '0; rx_len = '0;
      tx_start = 1'b1; rx_start = 1'b1;
      glb2io_17_ready = 1'b1; io2glb_17_valid = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      rx_start = 1'b0;
      #1;
      obs8 = {tx_done, rx_done, tx_busy, rx_busy, mem_rd_en, io2glb_17_ready, glb2io_17_valid, mem_wr_en};
      n_checks++;
      if (obs8 !== 8'b1111_0000) begin
         n_fails++;
         $display("FAIL len_zero_done got=%b exp=11110000", obs8);
      end
      @(negedge clk);
      #1;
      obs8 = {tx_done, rx_done, tx_busy, rx_busy, mem_rd_en, io2glb_17_ready, glb2io_17_valid, mem_wr_en};
      n_checks++;
      if (obs8 !== 8'b0000_0000) begin
         n_fails++;
         $display("FAIL len_zero_after got=%b exp=00000000", obs8);
      end
      drive_idle();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) bank[i] = mval(i);
      test_reset();
      test_tx_basic();
      test_tx_stall();
      test_tx_wrap();
      test_rx_basic();
      test_rx_wrap();
      test_clk_en();
      test_flush();
      test_rst_mid();
      test_len_zero();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
